// File: rtl/flash_rom_prefetch.sv
// ROM read front-end for the dual-IO SPI flash reader: serves word reads from a small
// sequential prefetch buffer. Define FLASH_PREFETCH_EN to enable speculative fills.
module flash_rom_prefetch #(
    parameter int unsigned PF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_valid,
    input  logic [22:0] rd_addr,
    output logic        rd_ready,
    output logic        rd_ack,
    output logic [15:0] rd_data,
    output logic [22:0] flash_addr,
    output logic        flash_cs,
    input  logic        flash_busy,
    input  logic [15:0] flash_dout,
    input  logic        flash_ready
);

    localparam int unsigned AW     = 23;
    localparam int unsigned DW     = 16;
    localparam int unsigned IDX_W  = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
    localparam int unsigned FILL_W = IDX_W + 1;

`ifdef FLASH_PREFETCH_EN
    localparam int unsigned     BUF_N           = PF_DEPTH;
    localparam logic [FILL_W-1:0] FILL_AFTER_MISS = FILL_W'(1);
`else
    // Single-entry buffer: fill index parks at PF_DEPTH so no speculative fetch is issued.
    localparam int unsigned     BUF_N           = 1;
    localparam logic [FILL_W-1:0] FILL_AFTER_MISS = FILL_W'(PF_DEPTH);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIT,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       base_q, base_d;
    logic [PF_DEPTH-1:0] valid_q, valid_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                demand_q, demand_d;
    logic [DW-1:0]       mem [PF_DEPTH];

    logic                ready_d, ack_d, cs_d;
    logic [DW-1:0]       data_d;
    logic [AW-1:0]       addr_d;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;

    logic [AW-1:0]       off;
    logic [IDX_W-1:0]    hit_idx;
    logic                hit;
    logic                pending;
    logic                launch_ok;

    // 23-bit modular offset makes buffers that straddle 0x7FFFFF hit naturally.
    assign off       = rd_addr - base_q;
    assign hit_idx   = off[IDX_W-1:0];
    assign hit       = (off < AW'(BUF_N)) && valid_q[hit_idx];
    assign pending   = fill_q < FILL_W'(PF_DEPTH);
    assign launch_ok = flash_ready && !flash_busy;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        valid_d  = valid_q;
        fill_d   = fill_q;
        demand_d = demand_q;
        addr_d   = flash_addr;
        data_d   = rd_data;
        cs_d     = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = '0;

        case (state_q)
            ST_IDLE: begin
                if (rd_valid) begin
                    if (hit) begin
                        state_d = ST_HIT;
                        data_d  = mem[hit_idx];
                    end else begin
                        state_d  = ST_REQ;
                        addr_d   = rd_addr;
                        demand_d = 1'b1;
                        cs_d     = launch_ok;
                    end
                end else if (pending && launch_ok) begin
                    state_d  = ST_REQ;
                    addr_d   = base_q + AW'(fill_q);
                    demand_d = 1'b0;
                    cs_d     = 1'b1;
                end
            end
            ST_HIT: begin
                state_d = ST_IDLE;
            end
            ST_REQ: begin
                // Only a busy seen after our own cs edge counts; stale transfers are ignored.
                if (flash_cs && flash_busy) begin
                    state_d = ST_WAIT;
                end else begin
                    cs_d = flash_cs || launch_ok;
                end
            end
            ST_WAIT: begin
                if (!flash_busy) begin
                    wr_en = 1'b1;
                    if (demand_q) begin
                        data_d     = flash_dout;
                        base_d     = flash_addr;
                        valid_d    = '0;
                        valid_d[0] = 1'b1;
                        wr_idx     = '0;
                        fill_d     = FILL_AFTER_MISS;
                        state_d    = ST_HIT;
                    end else begin
                        wr_idx          = fill_q[IDX_W-1:0];
                        valid_d[wr_idx] = 1'b1;
                        fill_d          = fill_q + FILL_W'(1);
                        state_d         = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // HIT doubles as the ack cycle for demand misses, keeping rd_ready low there.
        ready_d = (state_d == ST_IDLE);
        ack_d   = (state_d == ST_HIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            valid_q    <= '0;
            fill_q     <= FILL_W'(PF_DEPTH);
            demand_q   <= 1'b0;
            rd_ready   <= 1'b1;
            rd_ack     <= 1'b0;
            rd_data    <= '0;
            flash_cs   <= 1'b0;
            flash_addr <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            valid_q    <= valid_d;
            fill_q     <= fill_d;
            demand_q   <= demand_d;
            rd_ready   <= ready_d;
            rd_ack     <= ack_d;
            rd_data    <= data_d;
            flash_cs   <= cs_d;
            flash_addr <= addr_d;
        end
    end

    // Data array needs no reset; the valid bits guard every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= flash_dout;
        end
    end

endmodule

// File: tb/tb_flash_rom_prefetch.sv
// Self-checking bench for flash_rom_prefetch with a behavioural flash reader and buffer model.
module tb_flash_rom_prefetch;

    localparam int unsigned PF_DEPTH = 4;
`ifdef FLASH_PREFETCH_EN
    localparam int unsigned D_EFF = PF_DEPTH;
`else
    localparam int unsigned D_EFF = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_valid = 1'b0;
    logic [22:0] rd_addr = '0;
    logic        rd_ready;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic [22:0] flash_addr;
    logic        flash_cs;
    logic        flash_busy = 1'b0;
    logic [15:0] flash_dout = '0;
    logic        flash_ready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [22:0] xfers[$];
    logic        cs_q = 1'b0;
    int          busy_cnt = 0;
    logic [22:0] cur_addr = '0;
    logic        ack_prev = 1'b0;

    // Buffer model: after a settled miss at base_m, words base_m .. base_m+D_EFF-1 are held.
    logic [22:0] base_m = '0;
    bit          valid_m = 1'b0;

    flash_rom_prefetch #(.PF_DEPTH(PF_DEPTH)) dut (
        .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_ack(rd_ack), .rd_data(rd_data),
        .flash_addr(flash_addr), .flash_cs(flash_cs), .flash_busy(flash_busy),
        .flash_dout(flash_dout), .flash_ready(flash_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fdata(input logic [22:0] a);
        if (a == 23'h000100) return 16'hA55A;
        return a[15:0] ^ {a[22:16], a[8:0]} ^ 16'h3C96;
    endfunction

    function automatic bit exp_hit(input logic [22:0] a);
        logic [22:0] d;
        d = a - base_m;
        return valid_m && (int'(d) < int'(D_EFF));
    endfunction

    function automatic bit pf_list_ok(input int start, input logic [22:0] a);
        logic [22:0] e;
        if (xfers.size() != start + int'(D_EFF)) return 1'b0;
        for (int i = 0; i < int'(D_EFF); i++) begin
            e = a + 23'(i);
            if (xfers[start + i] !== e) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Flash reader: rising cs starts a transfer of random length; data valid when busy falls.
    always @(posedge clk) begin
        cs_q <= flash_cs;
        if (flash_busy) begin
            if (busy_cnt == 0) begin
                flash_busy <= 1'b0;
                flash_dout <= fdata(cur_addr);
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end else if (flash_cs && !cs_q) begin
            flash_busy <= 1'b1;
            busy_cnt   <= int'($urandom_range(2, 6));
            cur_addr   <= flash_addr;
            xfers.push_back(flash_addr);
        end
    end

    always @(negedge clk) begin
        if (rd_ack) begin
            n_tests++;
            if (ack_prev) begin
                n_fail++;
                $display("FAIL ack_back_to_back: rd_ack high in consecutive cycles at %0t", $time);
            end
        end
        ack_prev = rd_ack;
    end

    task automatic do_read(input logic [22:0] a, output logic [15:0] d, output int lat,
                           output logic rdy_at_ack);
        int n;
        d = '0; lat = 0; rdy_at_ack = 1'b0; n = 0;
        @(negedge clk);
        rd_valid = 1'b1;
        rd_addr  = a;
        while (!rd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!rd_ready) begin
            rd_valid = 1'b0;
            n_tests++; n_fail++;
            $display("FAIL read_accept_timeout: addr %06h never accepted", a);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        rd_valid = 1'b0;
        lat = 1;
        while (!rd_ack && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        if (!rd_ack) begin
            n_tests++; n_fail++;
            $display("FAIL read_ack_timeout: addr %06h no ack", a);
        end
        d = rd_data;
        rdy_at_ack = rd_ready;
    endtask

    task automatic settle();
        int stable = 0;
        int n = 0;
        while (stable < 4 && n < 1000) begin
            @(negedge clk);
            n++;
            if (rd_ready && !flash_busy && !flash_cs && flash_ready) stable++;
            else stable = 0;
        end
        if (stable < 4) begin
            n_tests++; n_fail++;
            $display("FAIL settle_timeout: block never returned to quiet IDLE");
        end
    endtask

    task automatic test_reset();
        int xs;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests += 5;
        if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rd_ready: got %b want 1", rd_ready); end
        if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ack: got %b want 0", rd_ack); end
        if (rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        if (flash_cs !== 1'b0) begin n_fail++; $display("FAIL reset_flash_cs: got %b want 0", flash_cs); end
        if (flash_addr !== 23'h0) begin n_fail++; $display("FAIL reset_flash_addr: got %h want 0", flash_addr); end
        xs = xfers.size();
        repeat (10) @(negedge clk);
        n_tests++;
        if (xfers.size() != 0 || xs != 0) begin
            n_fail++; $display("FAIL reset_no_prefetch: got %0d transfers want 0", xfers.size());
        end
    endtask

    task automatic test_demand_miss();
        logic [15:0] d; int lat; logic rdy; int xs;
        xs = xfers.size();
        do_read(23'h000100, d, lat, rdy);
        n_tests += 3;
        if (d !== 16'hA55A) begin n_fail++; $display("FAIL miss_data: got %h want a55a", d); end
        if (lat < 3) begin n_fail++; $display("FAIL miss_latency: got %0d want >=3", lat); end
        if (xfers.size() <= xs || xfers[xs] !== 23'h000100) begin
            n_fail++; $display("FAIL miss_xfer_addr: got %0d transfers want first 000100", xfers.size() - xs);
        end
        settle();
        n_tests++;
        if (!pf_list_ok(xs, 23'h000100)) begin
            n_fail++; $display("FAIL miss_prefetch_list: got %0d transfers want %0d", xfers.size() - xs, D_EFF);
        end
        base_m = 23'h000100; valid_m = 1'b1;
    endtask

    task automatic test_hits();
        logic [15:0] d; int lat; logic rdy; int xs; logic [22:0] a; bit h;
        for (int i = 1; i < 4; i++) begin
            a = 23'h000100 + 23'(i);
            h = exp_hit(a);
            xs = xfers.size();
            do_read(a, d, lat, rdy);
            n_tests += 2;
            if (d !== fdata(a)) begin n_fail++; $display("FAIL hit_data[%0d]: got %h want %h", i, d, fdata(a)); end
            if (h) begin
                if (lat != 1 || xfers.size() != xs || rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hit_timing[%0d]: lat %0d xfers %0d ready %b want 1/0/0", i, lat, xfers.size() - xs, rdy);
                end
            end else begin
                if (lat < 3 || xfers.size() <= xs) begin
                    n_fail++; $display("FAIL nohit_miss[%0d]: lat %0d xfers %0d want miss", i, lat, xfers.size() - xs);
                end
                settle();
                base_m = a; valid_m = 1'b1;
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] d; int lat; logic rdy; int xs; bit h;
        xs = xfers.size();
        do_read(23'h7FFFFE, d, lat, rdy);
        settle();
        n_tests += 2;
        if (d !== fdata(23'h7FFFFE)) begin n_fail++; $display("FAIL wrap_miss_data: got %h want %h", d, fdata(23'h7FFFFE)); end
        if (!pf_list_ok(xs, 23'h7FFFFE)) begin
            n_fail++; $display("FAIL wrap_prefetch_list: got %0d transfers want %0d", xfers.size() - xs, D_EFF);
        end
        base_m = 23'h7FFFFE; valid_m = 1'b1;
        h = exp_hit(23'h000000);
        xs = xfers.size();
        do_read(23'h000000, d, lat, rdy);
        n_tests += 2;
        if (d !== fdata(23'h000000)) begin n_fail++; $display("FAIL wrap_read_data: got %h want %h", d, fdata(23'h0)); end
        if (h ? (lat != 1 || xfers.size() != xs) : (lat < 3 || xfers.size() == xs)) begin
            n_fail++; $display("FAIL wrap_read_hit: lat %0d xfers %0d expected hit %b", lat, xfers.size() - xs, h);
        end
        if (!h) begin settle(); base_m = 23'h000000; end
    endtask

    task automatic test_blocked_during_prefetch();
        logic [15:0] d; int lat; logic rdy; int xs;
        do_read(23'h000300, d, lat, rdy);
`ifdef FLASH_PREFETCH_EN
        begin
            int n = 0;
            while (!(flash_busy && !flash_cs) && n < 50) begin @(negedge clk); n++; end
            n_tests++;
            if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL blocked_ready: got %b want 0 during prefetch", rd_ready); end
        end
`else
        settle();
`endif
        xs = xfers.size();
        do_read(23'h000200, d, lat, rdy);
        n_tests += 2;
        if (d !== fdata(23'h000200)) begin n_fail++; $display("FAIL blocked_data: got %h want %h", d, fdata(23'h200)); end
        if (xfers.size() <= xs || xfers[xs] !== 23'h000200) begin
            n_fail++; $display("FAIL blocked_demand_xfer: next transfer is not 000200");
        end
        settle();
        n_tests++;
        if (!pf_list_ok(xs, 23'h000200)) begin
            n_fail++; $display("FAIL blocked_rebase_list: got %0d transfers want %0d", xfers.size() - xs, D_EFF);
        end
        base_m = 23'h000200; valid_m = 1'b1;
    endtask

    task automatic test_not_ready();
        int cs_seen = 0; int n = 0;
        settle();
        @(negedge clk);
        flash_ready = 1'b0;
        rd_valid = 1'b1;
        rd_addr = 23'h000400;
        @(posedge clk);
        @(negedge clk);
        rd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (flash_cs) cs_seen++;
            @(negedge clk);
        end
        n_tests++;
        if (cs_seen != 0) begin n_fail++; $display("FAIL notready_cs_low: cs high %0d cycles want 0", cs_seen); end
        flash_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (flash_cs !== 1'b1) begin n_fail++; $display("FAIL notready_cs_rise: got %b want 1", flash_cs); end
        while (!rd_ack && n < 200) begin @(negedge clk); n++; end
        n_tests++;
        if (rd_ack !== 1'b1 || rd_data !== fdata(23'h000400)) begin
            n_fail++; $display("FAIL notready_data: ack %b data %h want 1/%h", rd_ack, rd_data, fdata(23'h400));
        end
        settle();
        base_m = 23'h000400; valid_m = 1'b1;
    endtask

    task automatic test_reset_in_wait();
        logic [15:0] d; int lat; logic rdy; int xs; int n = 0; int acks = 0;
        @(negedge clk);
        rd_valid = 1'b1;
        rd_addr = 23'h000500;
        @(posedge clk);
        @(negedge clk);
        rd_valid = 1'b0;
        while (!(flash_busy && !flash_cs) && n < 50) begin @(negedge clk); n++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rd_ack) acks++;
            @(negedge clk);
        end
        n_tests += 2;
        if (acks != 0) begin n_fail++; $display("FAIL rstwait_no_ack: got %0d acks want 0", acks); end
        if (rd_ready !== 1'b1 || flash_cs !== 1'b0 || rd_data !== 16'h0) begin
            n_fail++; $display("FAIL rstwait_state: ready %b cs %b data %h want 1/0/0000", rd_ready, flash_cs, rd_data);
        end
        valid_m = 1'b0;
        settle();
        xs = xfers.size();
        do_read(23'h000500, d, lat, rdy);
        n_tests += 2;
        if (lat < 3 || xfers.size() <= xs || xfers[xs] !== 23'h000500) begin
            n_fail++; $display("FAIL rstwait_remiss: lat %0d xfers %0d want miss at 000500", lat, xfers.size() - xs);
        end
        if (d !== fdata(23'h000500)) begin n_fail++; $display("FAIL rstwait_data: got %h want %h", d, fdata(23'h500)); end
        settle();
        base_m = 23'h000500; valid_m = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] d; int lat; logic rdy; int xs; logic [22:0] a; bit h;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) a = 23'($urandom);
            else a = base_m + 23'($urandom_range(0, PF_DEPTH));
            h = exp_hit(a);
            xs = xfers.size();
            do_read(a, d, lat, rdy);
            n_tests += 2;
            if (d !== fdata(a)) begin n_fail++; $display("FAIL rand_data[%0d]: addr %06h got %h want %h", it, a, d, fdata(a)); end
            if (h) begin
                if (lat != 1 || xfers.size() != xs) begin
                    n_fail++; $display("FAIL rand_hit[%0d]: addr %06h lat %0d xfers %0d want 1/0", it, a, lat, xfers.size() - xs);
                end
            end else begin
                if (lat < 3 || xfers.size() <= xs || xfers[xs] !== a) begin
                    n_fail++; $display("FAIL rand_miss[%0d]: addr %06h lat %0d xfers %0d", it, a, lat, xfers.size() - xs);
                end
                settle();
                n_tests++;
                if (!pf_list_ok(xs, a)) begin
                    n_fail++; $display("FAIL rand_prefetch[%0d]: addr %06h got %0d transfers want %0d", it, a, xfers.size() - xs, D_EFF);
                end
                base_m = a; valid_m = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_demand_miss();
        test_hits();
        test_wrap();
        test_blocked_during_prefetch();
        test_not_ready();
        test_reset_in_wait();
        test_random();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
